// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered 2-to-4 line decoder.
package decoder_pkg;

  localparam int A_W = 2;
  localparam int Y_W = 1 << A_W;

  typedef logic [A_W-1:0] sel_t;
  typedef logic [Y_W-1:0] onehot_t;

  localparam onehot_t Y_IDLE = 4'b0000;

endpackage : decoder_pkg

// File: rtl/decoder_2to4_core.sv
// Combinational decode table: one-hot line select when enabled, all-zero otherwise.
module decoder_2to4_core
  import decoder_pkg::*;
(
  input  logic    en,
  input  sel_t    a,
  output onehot_t y_next
);

  // Explicit table so every select value maps to exactly one line.
  always_comb begin
    y_next = Y_IDLE;
    if (en) begin
      unique case (a)
        2'b00:   y_next = 4'b0001;
        2'b01:   y_next = 4'b0010;
        2'b10:   y_next = 4'b0100;
        2'b11:   y_next = 4'b1000;
        default: y_next = Y_IDLE;
      endcase
    end
  end

endmodule : decoder_2to4_core

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 decoder with enable. The output register gives downstream
// chip-select / mux-enable consumers a glitch-free one-hot (or idle) vector.
module decoder_2to4
  import decoder_pkg::*;
#(
  parameter int A_W = decoder_pkg::A_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [A_W-1:0] a,
  output logic [Y_W-1:0] y
);

  onehot_t y_next;

  decoder_2to4_core u_core (
    .en     (en),
    .a      (a),
    .y_next (y_next)
  );

  // Output register; reset clears the selection without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= Y_IDLE;
    end else begin
      y <= y_next;
    end
  end

`ifndef SYNTHESIS
  // At most one line may ever be selected, reset cycles included.
  a_onehot0 : assert property (@(posedge clk) $countones(y) <= 1)
    else $error("decoder_2to4: more than one output line set, y=%b", y);

  // A disabled decoder must present the idle vector on the following cycle.
  a_en_off_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !en |=> (y == Y_IDLE))
    else $error("decoder_2to4: y not idle after en=0, y=%b", y);

  // Unknown inputs out of reset are a stimulus error upstream.
  a_inputs_known : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({en, a}))
    else $error("decoder_2to4: X/Z on inputs en=%b a=%b", en, a);
`endif

endmodule : decoder_2to4

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4 using an expected-value queue.
module tb_decoder_2to4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] a = 2'b00;
  logic [3:0] y;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  logic [3:0] prev_y;

  localparam logic [3:0] DEC_TBL [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  decoder_2to4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .y     (y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got y=%b required completion", y);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] model(input logic e, input logic [1:0] s);
    logic [3:0] r;
    r = 4'b0000;
    if (e) r[s] = 1'b1;
    return r;
  endfunction

  // Drive at the falling edge, record what the next rising edge must produce.
  task automatic drive(input logic e, input logic [1:0] s);
    @(negedge clk);
    en = e;
    a  = s;
    exp_q.push_back(model(e, s));
  endtask

  task automatic test_reset();
    #2;
    en    = 1'b1;
    a     = 2'b11;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 4'b0000) begin
      errors++;
      $display("FAIL reset_immediate: y=%b required 0000", y);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (y !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: y=%b required 0000", i, y);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'b1000);
    #1;
    checks++;
    if (y !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release_early: y=%b required 0000 before edge", y);
    end
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (y !== exp_v) begin
      errors++;
      $display("FAIL reset_release: y=%b required %b", y, exp_v);
    end
  endtask

  task automatic test_disabled_sweep();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i));
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (y !== exp_v || y !== 4'b0000) begin
        errors++;
        $display("FAIL disabled_sweep a=%0d: y=%b required 0000", i, y);
      end
    end
  endtask

  task automatic test_enabled_sweep();
    for (int i = 0; i < 4; i++) begin
      prev_y = y;
      drive(1'b1, 2'(i));
      #1;
      checks++;
      if (y !== prev_y) begin
        errors++;
        $display("FAIL enabled_latency a=%0d: y=%b required %b before edge", i, y, prev_y);
      end
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (y !== DEC_TBL[i] || y !== exp_v) begin
        errors++;
        $display("FAIL enabled_sweep a=%0d: y=%b required %b", i, y, DEC_TBL[i]);
      end
    end
  endtask

  task automatic test_enable_toggle();
    logic       en_seq [3];
    logic [3:0] req    [3];
    en_seq = '{1'b1, 1'b0, 1'b1};
    req    = '{4'b0100, 4'b0000, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      drive(en_seq[i], 2'b10);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (y !== req[i] || y !== exp_v) begin
        errors++;
        $display("FAIL enable_toggle step%0d: y=%b required %b", i, y, req[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 2'b01);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (y !== 4'b0010 || y !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_pre: y=%b required 0010", y);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_async: y=%b required 0000", y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(en, a));
    #1;
    checks++;
    if (y !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_lost: y=%b required 0000 before edge", y);
    end
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (y !== 4'b0010 || y !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_recover: y=%b required 0010", y);
    end
  endtask

  task automatic test_exhaustive();
    for (int e = 0; e < 2; e++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'(e), 2'(i));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (y !== exp_v) begin
          errors++;
          $display("FAIL exhaustive en=%0d a=%0d: y=%b required %b", e, i, y, exp_v);
        end
        checks++;
        if ($countones(y) > 1) begin
          errors++;
          $display("FAIL popcount en=%0d a=%0d: y=%b has %0d bits required <=1",
                   e, i, y, $countones(y));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       e;
    logic [1:0] s;
    for (int n = 0; n < 24; n++) begin
      e = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      drive(e, s);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL back_to_back[%0d]: scoreboard empty, y=%b required entry", n, y);
      end else begin
        exp_v = exp_q.pop_front();
        checks++;
        if (y !== exp_v) begin
          errors++;
          $display("FAIL back_to_back[%0d] en=%b a=%0d: y=%b required %b", n, e, s, y, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_disabled_sweep();
    test_enabled_sweep();
    test_enable_toggle();
    test_mid_reset();
    test_exhaustive();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_decoder_2to4
